// File: rtl/regfile_2r1w.sv
// Register file with 2**SEL entries, two registered read ports and one write port.
// Reads can optionally bypass a same-cycle write, and entry 0 can be hardwired to zero.
module regfile_2r1w #(
  parameter int BUS_WIDTH   = 32,
  parameter int SEL         = 5,
  parameter int ZERO_REG    = 1,
  parameter int WRITE_FIRST = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [SEL-1:0]       waddr,
  input  logic [BUS_WIDTH-1:0] wdata,
  input  logic                 ren_a,
  input  logic [SEL-1:0]       raddr_a,
  output logic [BUS_WIDTH-1:0] dout_a,
  output logic                 rvalid_a,
  input  logic                 ren_b,
  input  logic [SEL-1:0]       raddr_b,
  output logic [BUS_WIDTH-1:0] dout_b,
  output logic                 rvalid_b
);

  localparam int DEPTH = 1 << SEL;

  logic [BUS_WIDTH-1:0] mem_q [DEPTH];
  logic [BUS_WIDTH-1:0] mem_d [DEPTH];
  logic [BUS_WIDTH-1:0] dout_a_q, dout_a_d;
  logic [BUS_WIDTH-1:0] dout_b_q, dout_b_d;
  logic                 rvalid_a_q, rvalid_a_d;
  logic                 rvalid_b_q, rvalid_b_d;
  logic [BUS_WIDTH-1:0] sel_a;
  logic [BUS_WIDTH-1:0] sel_b;
  logic                 write_ok;

  // Writes to a hardwired-zero entry 0 are dropped so it stays at its reset value.
  always_comb begin
    write_ok = we && !((ZERO_REG != 0) && (waddr == '0));
  end

  always_comb begin
    mem_d = mem_q;
    if (write_ok) begin
      mem_d[waddr] = wdata;
    end
  end

  // Later assignments override earlier ones, so the zero-entry rule beats the bypass.
  always_comb begin
    sel_a = mem_q[raddr_a];
    if ((WRITE_FIRST != 0) && we && (waddr == raddr_a)) begin
      sel_a = wdata;
    end
    if ((ZERO_REG != 0) && (raddr_a == '0)) begin
      sel_a = '0;
    end
  end

  always_comb begin
    sel_b = mem_q[raddr_b];
    if ((WRITE_FIRST != 0) && we && (waddr == raddr_b)) begin
      sel_b = wdata;
    end
    if ((ZERO_REG != 0) && (raddr_b == '0)) begin
      sel_b = '0;
    end
  end

  always_comb begin
    dout_a_d   = ren_a ? sel_a : dout_a_q;
    rvalid_a_d = ren_a;
    dout_b_d   = ren_b ? sel_b : dout_b_q;
    rvalid_b_d = ren_b;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      dout_a_q   <= '0;
      dout_b_q   <= '0;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      dout_a_q   <= dout_a_d;
      dout_b_q   <= dout_b_d;
      rvalid_a_q <= rvalid_a_d;
      rvalid_b_q <= rvalid_b_d;
    end
  end

  assign dout_a   = dout_a_q;
  assign dout_b   = dout_b_q;
  assign rvalid_a = rvalid_a_q;
  assign rvalid_b = rvalid_b_q;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed bench for regfile_2r1w: default build, a ZERO_REG=0/WRITE_FIRST=0 build
// sharing its inputs, and a small SEL=3/BUS_WIDTH=8 build.
module tb_regfile_2r1w;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        ren_a;
  logic [4:0]  raddr_a;
  logic        ren_b;
  logic [4:0]  raddr_b;
  logic [31:0] dout_a, dout_b, alt_dout_a, alt_dout_b;
  logic        rvalid_a, rvalid_b, alt_rvalid_a, alt_rvalid_b;

  logic        s_we;
  logic [2:0]  s_waddr;
  logic [7:0]  s_wdata;
  logic        s_ren_a;
  logic [2:0]  s_raddr_a;
  logic        s_ren_b;
  logic [2:0]  s_raddr_b;
  logic [7:0]  s_dout_a, s_dout_b;
  logic        s_rvalid_a, s_rvalid_b;

  int checks;
  int errors;

  regfile_2r1w dut (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .ren_a(ren_a), .raddr_a(raddr_a), .dout_a(dout_a), .rvalid_a(rvalid_a),
    .ren_b(ren_b), .raddr_b(raddr_b), .dout_b(dout_b), .rvalid_b(rvalid_b)
  );

  regfile_2r1w #(.BUS_WIDTH(32), .SEL(5), .ZERO_REG(0), .WRITE_FIRST(0)) dut_alt (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .ren_a(ren_a), .raddr_a(raddr_a), .dout_a(alt_dout_a), .rvalid_a(alt_rvalid_a),
    .ren_b(ren_b), .raddr_b(raddr_b), .dout_b(alt_dout_b), .rvalid_b(alt_rvalid_b)
  );

  regfile_2r1w #(.BUS_WIDTH(8), .SEL(3)) dut_small (
    .clk(clk), .rst_n(rst_n), .we(s_we), .waddr(s_waddr), .wdata(s_wdata),
    .ren_a(s_ren_a), .raddr_a(s_raddr_a), .dout_a(s_dout_a), .rvalid_a(s_rvalid_a),
    .ren_b(s_ren_b), .raddr_b(s_raddr_b), .dout_b(s_dout_b), .rvalid_b(s_rvalid_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance past the next rising edge and settle one time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    we = 1'b0; waddr = '0; wdata = '0;
    ren_a = 1'b0; raddr_a = '0; ren_b = 1'b0; raddr_b = '0;
    s_we = 1'b0; s_waddr = '0; s_wdata = '0;
    s_ren_a = 1'b0; s_raddr_a = '0; s_ren_b = 1'b0; s_raddr_b = '0;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({dout_a, dout_b} !== 64'h0) begin
      errors++; $display("[TB] FAIL reset_douts: got %h %h expected 0 0", dout_a, dout_b);
    end
    checks++;
    if ({rvalid_a, rvalid_b, s_rvalid_a, s_rvalid_b} !== 4'b0000) begin
      errors++; $display("[TB] FAIL reset_rvalid: got %b expected 0000", {rvalid_a, rvalid_b, s_rvalid_a, s_rvalid_b});
    end
    rst_n = 1'b1;
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
    step();
    we = 1'b0; ren_a = 1'b1; raddr_a = 5'd5; ren_b = 1'b1; raddr_b = 5'd5;
    step();
    checks++;
    if ({dout_a, dout_b} !== {32'hDEADBEEF, 32'hDEADBEEF}) begin
      errors++; $display("[TB] FAIL prereset_read: got %h %h expected deadbeef deadbeef", dout_a, dout_b);
    end
    ren_a = 1'b0; ren_b = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({dout_a, dout_b} !== 64'h0) begin
      errors++; $display("[TB] FAIL async_reset_douts: got %h %h expected 0 0", dout_a, dout_b);
    end
    checks++;
    if ({rvalid_a, rvalid_b} !== 2'b00) begin
      errors++; $display("[TB] FAIL async_reset_rvalid: got %b expected 00", {rvalid_a, rvalid_b});
    end
    #2 rst_n = 1'b1;
    ren_a = 1'b1; raddr_a = 5'd5;
    step();
    checks++;
    if (dout_a !== 32'h0 || rvalid_a !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_cleared_entry5: got %h/%b expected 00000000/1", dout_a, rvalid_a);
    end
    idle_inputs();
  endtask

  task automatic test_basic();
    we = 1'b1; waddr = 5'd7; wdata = 32'h12345678;
    step();
    we = 1'b0; ren_a = 1'b1; raddr_a = 5'd7;
    step();
    checks++;
    if (dout_a !== 32'h12345678 || rvalid_a !== 1'b1) begin
      errors++; $display("[TB] FAIL basic_read: got %h/%b expected 12345678/1", dout_a, rvalid_a);
    end
    checks++;
    if (alt_dout_a !== 32'h12345678) begin
      errors++; $display("[TB] FAIL basic_read_alt: got %h expected 12345678", alt_dout_a);
    end
    ren_a = 1'b0; raddr_a = 5'd2;
    step();
    checks++;
    if (dout_a !== 32'h12345678 || rvalid_a !== 1'b0) begin
      errors++; $display("[TB] FAIL basic_hold: got %h/%b expected 12345678/0", dout_a, rvalid_a);
    end
    idle_inputs();
  endtask

  task automatic test_zero_reg();
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; ren_a = 1'b1; raddr_a = 5'd0;
    step();
    checks++;
    if (dout_a !== 32'h0 || alt_dout_a !== 32'h0) begin
      errors++; $display("[TB] FAIL zero_same_cycle: got %h %h expected 0 0", dout_a, alt_dout_a);
    end
    we = 1'b0; ren_b = 1'b1; raddr_b = 5'd0;
    step();
    checks++;
    if ({dout_a, dout_b} !== 64'h0) begin
      errors++; $display("[TB] FAIL zero_reg_read: got %h %h expected 0 0", dout_a, dout_b);
    end
    checks++;
    if ({alt_dout_a, alt_dout_b} !== {32'hFFFFFFFF, 32'hFFFFFFFF}) begin
      errors++; $display("[TB] FAIL nonzero_reg_read: got %h %h expected ffffffff ffffffff", alt_dout_a, alt_dout_b);
    end
    idle_inputs();
  endtask

  task automatic test_bypass();
    we = 1'b1; waddr = 5'd3; wdata = 32'hAAAA0000;
    step();
    wdata = 32'h5555FFFF; ren_a = 1'b1; raddr_a = 5'd3; ren_b = 1'b1; raddr_b = 5'd3;
    step();
    checks++;
    if ({dout_a, dout_b} !== {32'h5555FFFF, 32'h5555FFFF}) begin
      errors++; $display("[TB] FAIL write_first: got %h %h expected 5555ffff 5555ffff", dout_a, dout_b);
    end
    checks++;
    if ({alt_dout_a, alt_dout_b} !== {32'hAAAA0000, 32'hAAAA0000}) begin
      errors++; $display("[TB] FAIL read_first: got %h %h expected aaaa0000 aaaa0000", alt_dout_a, alt_dout_b);
    end
    we = 1'b0;
    step();
    checks++;
    if (alt_dout_a !== 32'h5555FFFF || dout_a !== 32'h5555FFFF) begin
      errors++; $display("[TB] FAIL read_after_write: got %h %h expected 5555ffff 5555ffff", alt_dout_a, dout_a);
    end
    idle_inputs();
  endtask

  task automatic test_dual_port();
    logic [31:0] exp_a, exp_b;
    int bad;
    for (int i = 0; i < 32; i++) begin
      we = 1'b1; waddr = 5'(i); wdata = 32'(i) * 32'h01010101;
      step();
    end
    we = 1'b0;
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      ren_a = 1'b1; raddr_a = 5'(i); ren_b = 1'b1; raddr_b = 5'(31 - i);
      step();
      exp_a = 32'(i) * 32'h01010101;
      exp_b = 32'(31 - i) * 32'h01010101;
      checks++;
      if ({dout_a, dout_b, alt_dout_a, alt_dout_b} !== {exp_a, exp_b, exp_a, exp_b}) begin
        errors++; bad++;
        if (bad < 4) $display("[TB] FAIL sweep_%0d: got %h %h %h %h expected %h %h", i, dout_a, dout_b, alt_dout_a, alt_dout_b, exp_a, exp_b);
      end
      checks++;
      if ({rvalid_a, rvalid_b, alt_rvalid_a, alt_rvalid_b} !== 4'b1111) begin
        errors++; $display("[TB] FAIL sweep_rvalid_%0d: got %b expected 1111", i, {rvalid_a, rvalid_b, alt_rvalid_a, alt_rvalid_b});
      end
    end
    idle_inputs();
  endtask

  task automatic test_small();
    logic [7:0] exp_a, exp_b;
    for (int i = 0; i < 8; i++) begin
      s_we = 1'b1; s_waddr = 3'(i); s_wdata = 8'(i * 17);
      step();
    end
    s_we = 1'b0;
    for (int i = 0; i < 8; i++) begin
      s_ren_a = 1'b1; s_raddr_a = 3'(i); s_ren_b = 1'b1; s_raddr_b = 3'(7 - i);
      step();
      exp_a = 8'(i * 17);
      exp_b = 8'((7 - i) * 17);
      checks++;
      if ({s_dout_a, s_dout_b, s_rvalid_a, s_rvalid_b} !== {exp_a, exp_b, 2'b11}) begin
        errors++; $display("[TB] FAIL small_sweep_%0d: got %h %h %b%b expected %h %h 11", i, s_dout_a, s_dout_b, s_rvalid_a, s_rvalid_b, exp_a, exp_b);
      end
    end
    idle_inputs();
  endtask

  task automatic test_same_addr();
    ren_a = 1'b1; raddr_a = 5'd9; ren_b = 1'b1; raddr_b = 5'd9;
    we = 1'b1; waddr = 5'd10; wdata = 32'hCAFEF00D;
    step();
    checks++;
    if ({dout_a, dout_b, alt_dout_a, alt_dout_b} !== {4{32'h09090909}}) begin
      errors++; $display("[TB] FAIL same_addr_read: got %h %h %h %h expected 09090909", dout_a, dout_b, alt_dout_a, alt_dout_b);
    end
    we = 1'b0; raddr_a = 5'd10; ren_b = 1'b0;
    step();
    checks++;
    if (dout_a !== 32'hCAFEF00D || alt_dout_a !== 32'hCAFEF00D) begin
      errors++; $display("[TB] FAIL other_addr_written: got %h %h expected cafef00d", dout_a, alt_dout_a);
    end
    checks++;
    if (dout_b !== 32'h09090909 || rvalid_b !== 1'b0) begin
      errors++; $display("[TB] FAIL port_b_idle_hold: got %h/%b expected 09090909/0", dout_b, rvalid_b);
    end
    idle_inputs();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_basic();
    test_zero_reg();
    test_bypass();
    test_dual_port();
    test_small();
    test_same_addr();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_2r1w.md
Name: regfile_2r1w

Overview:
Parametrised register file: 2**SEL entries of BUS_WIDTH bits, two independent registered read ports and one write port. Selection logic is the 32:1 bus-select structure generalised, with storage, read enables, read-valid strobes and configurable read-during-write bypass. Sits in the processor datapath between decode (read addresses) and writeback (write port).

Parameters:
BUS_WIDTH, 32, bits per entry and per data port
SEL, 5, address bits; depth = 2**SEL
ZERO_REG, 1, 1 = entry 0 hardwired to zero (writes ignored, reads return 0)
WRITE_FIRST, 1, 1 = same-cycle read of the address being written returns the new data; 0 = returns the old data

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
we  input  1  write enable
waddr  input  SEL  write address
wdata  input  BUS_WIDTH  write data
ren_a  input  1  read enable, port A
raddr_a  input  SEL  read address, port A
dout_a  output  BUS_WIDTH  registered read data, port A
rvalid_a  output  1  port A data valid strobe
ren_b  input  1  read enable, port B
raddr_b  input  SEL  read address, port B
dout_b  output  BUS_WIDTH  registered read data, port B
rvalid_b  output  1  port B data valid strobe

Behaviour:
- Reset: rst_n low forces, immediately and independently of clk, all 2**SEL entries, dout_a, dout_b = 0 and rvalid_a, rvalid_b = 0. Held while rst_n low; clocked operation resumes at the first rising edge after rst_n goes high. Reset asserted mid-operation discards any write or read in that cycle.
- Write: at rising edge with we=1, mem[waddr] <= wdata. Exception: ZERO_REG=1 and waddr=0 -> no change.
- Read latency: 1 cycle. At rising edge with ren_x=1, dout_x <= selected value and rvalid_x <= 1. With ren_x=0, dout_x holds its previous value and rvalid_x <= 0. rvalid_x is a one-cycle strobe per accepted read; back-to-back enables keep it high.
- Selected value, in priority order: (1) ZERO_REG=1 and raddr_x=0 -> 0; (2) WRITE_FIRST=1, we=1, waddr=raddr_x -> wdata; (3) otherwise mem[raddr_x], the pre-edge contents.
- Ports A and B are fully independent. Both may read the same address in the same cycle and both return identical data. Bypass applies to each port separately.
- Write to address 0 with ZERO_REG=1 and a same-cycle read of address 0 -> read returns 0, bypass is not applied.
- WRITE_FIRST=0 and same-address read/write -> read returns the old value. The new value is visible to reads issued on the next cycle.
- Address range is exactly 2**SEL, so no out-of-range addresses exist.
- Storage has no reset dependence beyond the reset clear. There are no X outputs after reset.

Test Plan:
- Reset: pulse rst_n low between clock edges after writing 0xDEADBEEF to entry 5 -> dout_a/b = 0 and rvalid = 0 immediately. A read of 5 after release -> 0x00000000.
- Basic write/read: write 0x12345678 to 7. Next cycle ren_a=1, raddr_a=7 -> dout_a = 0x12345678 one edge later, rvalid_a pulses one cycle. Then ren_a=0 -> dout_a holds 0x12345678, rvalid_a = 0.
- Zero register (ZERO_REG=1): write 0xFFFFFFFF to 0, then read 0 on both ports -> 0x00000000. With ZERO_REG=0, the same sequence -> 0xFFFFFFFF.
- Bypass (WRITE_FIRST=1): entry 3 = 0xAAAA0000. Same cycle we=1, waddr=3, wdata=0x5555FFFF, ren_a=1, raddr_a=3 -> dout_a = 0x5555FFFF. Repeat with WRITE_FIRST=0 -> dout_a = 0xAAAA0000, and the next read -> 0x5555FFFF.
- Dual port: fill entry i with i*0x01010101 for all 32 entries. Sweep raddr_a 0..31 ascending and raddr_b 31..0 descending, both enabled every cycle -> each dout matches its address with 1-cycle latency, and rvalid_a and rvalid_b stay high throughout. Run at SEL=3, BUS_WIDTH=8 as well.
- Same-address dual read plus write to another address: raddr_a=raddr_b=9, waddr=10 -> both douts = mem[9], and entry 10 is updated.
